// File: rtl/sobel_frame_ctrl.sv
// Frame-level sequencer in front of sobel_top: gates one frame of pixels at a time,
// tracks input/output beats, drains the pipeline and applies configuration only between frames.
module sobel_frame_ctrl #(
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter logic [8:0]  DEF_THRESH = 9'd100,
  parameter logic        DEF_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont_mode,
  input  logic [8:0]  cfg_threshold,
  input  logic        cfg_sobel_en,
  input  logic        cfg_update,
  input  logic [23:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [23:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic        o_valid,
  input  logic        o_ready,
  output logic [8:0]  threshold,
  output logic        sobel_en,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        err
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [8:0]       thresh_q, thresh_d;
  logic             en_q, en_d;
  logic [8:0]       sh_thresh_q, sh_thresh_d;
  logic             sh_en_q, sh_en_d;
  logic             pending_q, pending_d;
  logic             start_pend_q, start_pend_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             err_q, err_d;

  logic gate, in_acc, out_acc, counting, out_inc, last_in, out_full;

  // Zero-latency pass-through, open only while the frame is being fed
  assign gate    = (state_q == S_RUN);
  assign m_data  = s_data;
  assign m_valid = s_valid & gate;
  assign s_ready = m_ready & gate;

  assign in_acc   = s_valid & s_ready;
  assign out_acc  = o_valid & o_ready;
  assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign out_inc  = out_acc && counting && (out_cnt_q != CNT_W'(NPIX));
  assign last_in  = in_acc && (in_cnt_q == CNT_W'(NPIX - 1));
  assign out_full = out_inc && (out_cnt_q == CNT_W'(NPIX - 1));

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    thresh_d     = thresh_q;
    en_d         = en_q;
    sh_thresh_d  = sh_thresh_q;
    sh_en_d      = sh_en_q;
    pending_d    = pending_q;
    start_pend_d = start_pend_q;
    frame_cnt_d  = frame_cnt_q;
    err_d        = err_q;

    if (cfg_update) begin
      sh_thresh_d = cfg_threshold;
      sh_en_d     = cfg_sobel_en;
      pending_d   = 1'b1;
    end
    // Beats outside a frame or past the frame size are flagged and not counted
    if (out_acc && !out_inc) err_d = 1'b1;
    if (out_inc) out_cnt_d = out_cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          thresh_d = sh_thresh_q;
          en_d     = sh_en_q;
          if (!cfg_update) pending_d = 1'b0;
        end
        if (start) begin
          state_d   = S_RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (start) start_pend_d = 1'b1;
        if (in_acc) in_cnt_d = in_cnt_q + CNT_W'(1);
        if (last_in) state_d = out_full ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (start) start_pend_d = 1'b1;
        if (out_full) state_d = S_DONE;
      end
      default: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (cfg_update) begin
          thresh_d  = cfg_threshold;
          en_d      = cfg_sobel_en;
          pending_d = 1'b0;
        end else if (pending_q) begin
          thresh_d  = sh_thresh_q;
          en_d      = sh_en_q;
          pending_d = 1'b0;
        end
        start_pend_d = 1'b0;
        if (cont_mode || start_pend_q || start) begin
          state_d   = S_RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    // Pending settings become visible in the DONE cycle itself
    if ((state_d == S_DONE) && (state_q != S_DONE) && pending_q) begin
      thresh_d  = sh_thresh_q;
      en_d      = sh_en_q;
      pending_d = cfg_update;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      thresh_q     <= DEF_THRESH;
      en_q         <= DEF_EN;
      sh_thresh_q  <= DEF_THRESH;
      sh_en_q      <= DEF_EN;
      pending_q    <= 1'b0;
      start_pend_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      thresh_q     <= thresh_d;
      en_q         <= en_d;
      sh_thresh_q  <= sh_thresh_d;
      sh_en_q      <= sh_en_d;
      pending_q    <= pending_d;
      start_pend_q <= start_pend_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
    end
  end

  assign threshold  = thresh_q;
  assign sobel_en   = en_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign frame_cnt  = frame_cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with an 8x4 frame and a 5-cycle sobel_top stand-in.
module tb_sobel_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cont_mode, cfg_sobel_en, cfg_update;
  logic [8:0]  cfg_threshold;
  logic [23:0] s_data, m_data;
  logic        s_valid, s_ready, m_valid, m_ready, o_valid, o_ready;
  logic [8:0]  threshold;
  logic        sobel_en, busy, frame_done, err;
  logic [15:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(.IMG_W(8), .IMG_H(4), .DEF_THRESH(9'd100), .DEF_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .cont_mode(cont_mode),
    .cfg_threshold(cfg_threshold), .cfg_sobel_en(cfg_sobel_en), .cfg_update(cfg_update),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .o_valid(o_valid), .o_ready(o_ready),
    .threshold(threshold), .sobel_en(sobel_en), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .err(err)
  );

  // sobel_top stand-in: fixed 5-cycle latency, one output per accepted input
  logic [4:0] pipe;
  int         matured;
  logic       inject;
  logic       model_ov;
  assign model_ov = (matured != 0);
  assign o_valid  = model_ov | inject;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe    <= '0;
      matured <= 0;
    end else begin
      pipe    <= {pipe[3:0], m_valid & m_ready};
      matured <= matured + int'(pipe[4]) - int'(model_ov & o_ready);
    end
  end

  int in_seen = 0, out_seen = 0, done_seen = 0;
  always @(posedge clk) begin
    in_seen   <= in_seen + int'(s_valid & s_ready);
    out_seen  <= out_seen + int'(o_valid & o_ready);
    done_seen <= done_seen + int'(frame_done);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (frame_done) seen = 1'b1;
    end
    if (!seen) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int ib, ob, db, frames, gap_bad, cfg_bad;
    bit prev_done, ok;
    rst = 1'b1; start = 0; cont_mode = 0; cfg_threshold = '0; cfg_sobel_en = 0;
    cfg_update = 0; s_data = 24'h123456; s_valid = 0; m_ready = 1; o_ready = 1; inject = 0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_thresh", threshold, 100);
    chk("rst_en", sobel_en, 1);
    chk("rst_sready", s_ready, 0);
    rst = 1'b0;

    // 1: single frame with continuous source
    s_valid = 1'b1;
    ib = in_seen; ob = out_seen;
    pulse_start();
    chk("t1_passthru", m_data, 24'h123456);
    for (int i = 0; i < 100 && (in_seen - ib) < 32; i++) step();
    chk("t1_in32", in_seen - ib, 32);
    chk("t1_sready_drop", s_ready, 0);
    chk("t1_mvalid_drop", m_valid, 0);
    chk("t1_busy_drain", busy, 1);
    for (int i = 0; i < 100 && (out_seen - ob) < 32; i++) step();
    chk("t1_done_timing", frame_done, 1);
    step();
    chk("t1_in_total", in_seen - ib, 32);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_err", err, 0);
    chk("t1_idle", busy, 0);

    // 2: configuration change mid-frame is deferred to DONE
    pulse_start();
    step(); step(); step();
    cfg_threshold = 9'd200; cfg_sobel_en = 1'b0; cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    chk("t2_hold_thresh", threshold, 100);
    cfg_bad = 0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (frame_done) ok = 1'b1;
      else if (threshold !== 9'd100 || sobel_en !== 1'b1) cfg_bad++;
    end
    chk("t2_done_seen", ok, 1);
    chk("t2_no_mid_change", cfg_bad, 0);
    chk("t2_thresh_done", threshold, 200);
    chk("t2_en_done", sobel_en, 0);
    step();
    chk("t2_frame_cnt", frame_cnt, 2);
    chk("t2_thresh_after", threshold, 200);

    // 3: continuous mode, three frames with random stalls
    cont_mode = 1'b1;
    ib = in_seen; ob = out_seen; db = done_seen;
    frames = 0; gap_bad = 0; prev_done = 1'b0;
    pulse_start();
    for (int i = 0; i < 3000 && frames < 3; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      o_ready = ($urandom_range(0, 3) != 0);
      step();
      if (prev_done && s_ready !== 1'b1) gap_bad++;
      if (prev_done && frames == 2) cont_mode = 1'b0;
      prev_done = 1'b0;
      if (frame_done) begin
        frames++;
        prev_done = (frames < 3);
      end
    end
    s_valid = 1'b1; o_ready = 1'b1; cont_mode = 1'b0;
    step();
    chk("t3_frames", frames, 3);
    chk("t3_in96", in_seen - ib, 96);
    chk("t3_out96", out_seen - ob, 96);
    chk("t3_pulses", done_seen - db, 3);
    chk("t3_no_gap", gap_bad, 0);
    chk("t3_frame_cnt", frame_cnt, 5);
    chk("t3_idle", busy, 0);

    // 4: start held during RUN yields exactly one extra frame
    pulse_start();
    start = 1'b1;
    for (int i = 0; i < 5; i++) step();
    start = 1'b0;
    wait_done(200, "t4_first_timeout");
    step();
    chk("t4_restart", busy, 1);
    wait_done(200, "t4_second_timeout");
    step();
    chk("t4_idle", busy, 0);
    chk("t4_frame_cnt", frame_cnt, 7);
    for (int i = 0; i < 60; i++) step();
    chk("t4_no_third", frame_cnt, 7);
    chk("t4_still_idle", busy, 0);

    // 5: stray output beat in IDLE sets sticky err
    inject = 1'b1;
    step();
    inject = 1'b0;
    chk("t5_err_set", err, 1);
    chk("t5_cnt_same", frame_cnt, 7);
    step(); step();
    chk("t5_err_sticky", err, 1);
    ib = in_seen;
    pulse_start();
    wait_done(200, "t5_timeout");
    step();
    chk("t5_in32", in_seen - ib, 32);
    chk("t5_frame_cnt", frame_cnt, 8);
    chk("t5_err_kept", err, 1);

    // 6: reset mid-frame
    ib = in_seen;
    pulse_start();
    for (int i = 0; i < 50 && (in_seen - ib) < 10; i++) step();
    chk("t6_in10", in_seen - ib, 10);
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_sready", s_ready, 0);
    chk("t6_mvalid", m_valid, 0);
    chk("t6_cnt", frame_cnt, 0);
    chk("t6_err", err, 0);
    chk("t6_thresh", threshold, 100);
    chk("t6_en", sobel_en, 1);
    step();
    rst = 1'b0;
    ib = in_seen; ob = out_seen;
    pulse_start();
    wait_done(200, "t6_timeout");
    step();
    chk("t6_full_in", in_seen - ib, 32);
    chk("t6_full_out", out_seen - ob, 32);
    chk("t6_frame_cnt", frame_cnt, 1);
    chk("t6_err_clear", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
